sensor_preproc_pipe: RTL

SENSOR_PREPROC_PIPE -- requirements
Module: sensor_preproc_pipe

---
 rtl/sensor_preproc_pipe_if.sv | 28 ++
 rtl/sensor_preproc_pipe.sv | 82 ++++++++
 2 files changed

// File: rtl/sensor_preproc_pipe_if.sv
// sensor_preproc_pipe_if: valid/ready sample stream plus fault and clip sideband for sensor_preproc_pipe.
// The master modport is the producer/consumer side; the slave modport is the pipe itself.
interface sensor_preproc_pipe_if #(
    parameter int NUM_CH = 16,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] raw_vector;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*DATA_W-1:0] normalized_vector;
    logic [NUM_CH-1:0]        error_flags;
    logic [NUM_CH-1:0]        fault_flags;
    logic [NUM_CH-1:0]        fault_clear;
    logic [CNT_W-1:0]         clip_count;

    modport master (
        output in_valid, raw_vector, out_ready, fault_clear,
        input  in_ready, out_valid, normalized_vector, error_flags, fault_flags, clip_count
    );

    modport slave (
        input  in_valid, raw_vector, out_ready, fault_clear,
        output in_ready, out_valid, normalized_vector, error_flags, fault_flags, clip_count
    );
endinterface

// File: rtl/sensor_preproc_pipe.sv
// sensor_preproc_pipe: one-stage range check and clip/hold of a sensor vector,
// with per-channel persistent-fault detection and a saturating clip event counter.
module sensor_preproc_pipe #(
    parameter int NUM_CH       = 16,
    parameter int DATA_W       = 16,
    parameter int MIN_VAL      = -16384,
    parameter int MAX_VAL      = 16383,
    parameter int HOLD_MODE    = 0,
    parameter int FAULT_THRESH = 4,
    parameter int CNT_W        = 16
) (
    input logic clk,
    input logic rst,
    sensor_preproc_pipe_if.slave bus
);
    localparam int PW = $clog2(NUM_CH + 1);
    localparam int SW = CNT_W + PW;
    localparam logic signed [DATA_W-1:0] MIN_S = DATA_W'(MIN_VAL);
    localparam logic signed [DATA_W-1:0] MAX_S = DATA_W'(MAX_VAL);
    localparam logic [7:0] THRESH = 8'(FAULT_THRESH);

    logic                     accept;
    logic [NUM_CH-1:0]        oor;
    logic [NUM_CH-1:0]        set_fault;
    logic [NUM_CH*DATA_W-1:0] norm_d;
    logic [PW-1:0]            pop;
    logic [SW-1:0]            sum;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] s;
        logic signed [DATA_W-1:0] last_good;
        logic [7:0]               run;
        logic                     lo;
        logic                     hi;

        assign s       = bus.raw_vector[c*DATA_W +: DATA_W];
        assign lo      = s < MIN_S;
        assign hi      = s > MAX_S;
        assign oor[c]  = lo || hi;
        assign norm_d[c*DATA_W +: DATA_W] = (HOLD_MODE != 0) ? (oor[c] ? last_good : s)
                                          : lo ? MIN_S : hi ? MAX_S : s;
        // the fault fires only on the transition into the threshold, so a clear sticks while the run stays saturated
        assign set_fault[c] = accept && oor[c] && run == THRESH - 8'd1;

        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                last_good <= '0;
                run       <= '0;
            end else if (accept) begin
                if (!oor[c]) last_good <= s;
                run <= !oor[c] ? 8'd0 : (run == THRESH) ? run : run + 8'd1;
            end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) pop = pop + PW'(oor[i]);
        sum = SW'(bus.clip_count) + SW'(pop);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.out_valid         <= 1'b0;
            bus.normalized_vector <= '0;
            bus.error_flags       <= '0;
            bus.fault_flags       <= '0;
            bus.clip_count        <= '0;
        end else begin
            if (accept) begin
                bus.out_valid         <= 1'b1;
                bus.normalized_vector <= norm_d;
                bus.error_flags       <= oor;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            bus.fault_flags <= (bus.fault_flags & ~bus.fault_clear) | set_fault;
            if (accept) bus.clip_count <= (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
endmodule
